// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: in-order imem requests, DEPTH-entry queue, redirect flush.
// Define IF_PERF_CNT_EN to add saturating perf_fetched/perf_stall/perf_flush outputs.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        fetch_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [PW-1:0] LAST    = PW'(DEPTH - 1);

    logic [31:0]   pc;
    logic [31:0]   rpc;
    logic [CW-1:0] count;
    logic [CW-1:0] outst;
    logic [CW-1:0] drop;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   q_instr [DEPTH];
    logic [31:0]   q_pc    [DEPTH];
    logic [31:0]   last_instr;
    logic [31:0]   last_pc;
    logic [31:0]   last_pc4;

    logic          has_head;
    logic          pop;
    logic          ret;
    logic          enq;
    logic [CW:0]   occ;
    logic [CW-1:0] outst_left;
    logic [31:0]   tgt;
    logic          unused_tgt;

    assign has_head   = (count != '0);
    assign id_valid   = has_head & ~redirect;
    assign pop        = id_valid & id_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign ret        = imem_rvalid & (outst != '0);
    assign enq        = ret & ~redirect & (drop == '0);
    assign occ        = {1'b0, count} + {1'b0, outst} - {{CW{1'b0}}, pop};
    assign imem_req   = fetch_en & ~redirect & ~reset & (occ < DEPTH_C);
    assign imem_addr  = pc;
    assign outst_left = ret ? outst - ONE : outst;
    assign tgt        = {redirect_pc[31:2], 2'b00};
    assign unused_tgt = ^redirect_pc[1:0];

    assign id_instr = has_head ? q_instr[rd_ptr] : last_instr;
    assign id_pc    = has_head ? q_pc[rd_ptr] : last_pc;
    assign id_pc4   = has_head ? q_pc[rd_ptr] + 32'd4 : last_pc4;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (enq) begin
            q_instr[wr_ptr] <= imem_rdata;
            q_pc[wr_ptr]    <= rpc;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            rpc        <= RESET_PC;
            count      <= '0;
            outst      <= '0;
            drop       <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            last_instr <= '0;
            last_pc    <= '0;
            last_pc4   <= '0;
        end else begin
            // Keep the last presented head so outputs hold once empty.
            if (has_head) begin
                last_instr <= q_instr[rd_ptr];
                last_pc    <= q_pc[rd_ptr];
                last_pc4   <= q_pc[rd_ptr] + 32'd4;
            end
            if (redirect) begin
                pc     <= tgt;
                rpc    <= tgt;
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
                outst  <= outst_left;
                drop   <= outst_left;
            end else begin
                if (imem_req)
                    pc <= pc + 32'd4;
                case ({imem_req, ret})
                    2'b10:   outst <= outst + ONE;
                    2'b01:   outst <= outst - ONE;
                    default: outst <= outst;
                endcase
                if (ret && drop != '0)
                    drop <= drop - ONE;
                if (enq) begin
                    rpc    <= rpc + 32'd4;
                    wr_ptr <= nxt(wr_ptr);
                end
                if (pop)
                    rd_ptr <= nxt(rd_ptr);
                case ({enq, pop})
                    2'b10:   count <= count + ONE;
                    2'b01:   count <= count - ONE;
                    default: count <= count;
                endcase
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
            perf_flush   <= '0;
        end else begin
            if (enq && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (id_valid && !id_ready && perf_stall != '1)
                perf_stall <= perf_stall + 32'd1;
            if (redirect && perf_flush != '1)
                perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule
